control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port clear, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port IR, input, 32, instruction register contents; opcode is IR[31:27].
REQ-004 SHALL have port CON_FF, input, 1, branch-condition flag from the datapath.
REQ-005 SHALL have port Stop, input, 1, halt request, sampled only on an instruction's final step.
REQ-006 SHALL have port Run, output, 1, high while executing instructions.
REQ-007 SHALL have port ALU_op, output, 4, ALU select: ADD=0000, SUB=0001, AND=0010, OR=0011, MUL=0100, DIV=0101; ADD when unused.
REQ-008 SHALL have bus-drive outputs, 1 bit each: PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout.
REQ-009 SHALL have latch outputs, 1 bit each: PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin, CONin.
REQ-010 SHALL have misc outputs, 1 bit each: IncPC, Read, Write, Gra, Grb, Grc.

Function
REQ-011 SHALL be a Moore FSM; every control output is a function of state only, asserted for exactly one clock per state, otherwise 0.
REQ-012 SHALL have states RST, T0..T7 and HALT; states not listed for an opcode are skipped.
REQ-013 Fetch SHALL be: T0 PCout MARin IncPC PCin; T1 Read MDRin; T2 MDRout IRin; then T3.
REQ-014 Decode SHALL use IR in T3 and later; IR is not sampled before T3.
REQ-015 add/sub/and/or (00011/00100/00101/00110) SHALL be: T3 Grb Rout Yin; T4 Grc Rout Zlowin with matching ALU_op; T5 Zlowout Gra Rin.
REQ-016 ld (00000) SHALL be: T3 Grb BAout Yin; T4 Cout Zlowin ALU_op=ADD; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
REQ-017 st (00010) SHALL match ld through T5, then: T6 Gra Rout MDRin; T7 Write.
REQ-018 branch (10010) SHALL be: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zlowin ALU_op=ADD; T6 Zlowout PCin only if CON_FF=1 in T6, else all outputs 0.
REQ-019 nop (11010) and every undefined opcode SHALL use T3 with all outputs 0, then T0.
REQ-020 halt (11011) SHALL go T3 -> HALT; HALT holds with Run=0 until clear.
REQ-021 After an instruction's final step, next state SHALL be HALT if Stop=1, else T0.
REQ-022 Run SHALL be 1 in T0..T7 and 0 in RST and HALT.
REQ-023 Latency SHALL be 6 clocks for ALU ops, 8 for ld/st, 7 for branch, 4 for nop, from T0 entry to the next T0.

Reset
REQ-024 clear=1 at a rising edge SHALL force RST from any state, including mid-instruction and HALT; all outputs 0, ALU_op=ADD.
REQ-025 The first edge with clear=0 SHALL move RST -> T0.
REQ-026 clear SHALL take priority over Stop and over any opcode transition.

Configuration
REQ-027 With MULDIV_EN defined, mul (01111) and div (10000) SHALL be: T3 Gra Rout Yin; T4 Grb Rout Zlowin Zhighin with ALU_op MUL/DIV; T5 Zlowout LOin; T6 Zhighout HIin.
REQ-028 Without MULDIV_EN, mul and div SHALL decode as nop, and HIin, LOin and Zhighin SHALL be constant 0.

Structure
REQ-029 A shared package SHALL hold the opcode constants, ALU_op codes and the state enumeration.
REQ-030 One sub-module, instr_decoder, SHALL map IR[31:27] to a one-hot instruction class.

Verification
REQ-031 clear 2 clocks, release, IR=0x18918000 (add r1,r2,r3): T0..T5 in order, ALU_op=0000 in T4, Gra+Rin in T5, T0 follows.
REQ-032 IR=0x92800005 (branch), CON_FF=1 in T6: Zlowout+PCin high in T6; repeat with CON_FF=0: no output high in T6.
REQ-033 IR=0x00900010 (ld r1,0x10(r2)): BAout in T3, MARin in T5, Read in T6, Gra+Rin in T7; 8-clock latency.
REQ-034 IR=0xD8000000 (halt): HALT entered after T3, Run=0 for 20 clocks; clear then restarts T0.
REQ-035 Stop=1 on the T5 of an add: next state HALT; clear asserted in T4 of a st: RST next, Write never asserted.
REQ-036 IR opcode 01111 in both builds: MULDIV_EN gives LOin in T5 and HIin in T6; without it, T3 idle then T0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU select codes, FSM states
// and the one-hot instruction class layout produced by instr_decoder.
package control_unit_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam int CLS_W    = 7;
  localparam int CLS_ALU  = 0;
  localparam int CLS_LD   = 1;
  localparam int CLS_ST   = 2;
  localparam int CLS_BR   = 3;
  localparam int CLS_HALT = 4;
  localparam int CLS_MD   = 5;
  localparam int CLS_NOP  = 6;

  function automatic logic [3:0] alu_sel(input logic [4:0] opcode);
    case (opcode)
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      OP_MUL:  alu_sel = ALU_MUL;
      OP_DIV:  alu_sel = ALU_DIV;
      default: alu_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Maps the 5-bit opcode to a one-hot instruction class.
// mul/div get their own class only when MULDIV_EN is defined; otherwise they fall to nop.
module instr_decoder
  import control_unit_pkg::*;
(
  input  logic [4:0]       i_opcode,
  output logic [CLS_W-1:0] o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: o_class[CLS_ALU]  = 1'b1;
      OP_LD:                         o_class[CLS_LD]   = 1'b1;
      OP_ST:                         o_class[CLS_ST]   = 1'b1;
      OP_BR:                         o_class[CLS_BR]   = 1'b1;
      OP_HALT:                       o_class[CLS_HALT] = 1'b1;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV:                o_class[CLS_MD]   = 1'b1;
`endif
      default:                       o_class[CLS_NOP]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: fetch T0-T2, execute T3-T7, HALT until clear.
// Optional MULDIV_EN adds mul/div sequencing and drives HIin/LOin/Zhighin.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic [3:0]  ALU_op,
  output logic        PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout,
  output logic        PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin,
  output logic        HIin, LOin, Rin, CONin,
  output logic        IncPC, Read, Write, Gra, Grb, Grc
);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_last;
  logic [CLS_W-1:0]   w_class;
  logic [4:0]         w_opcode;
  logic               w_alu, w_ld, w_st, w_br, w_halt, w_nop;
  logic               w_unused_ir;

  assign w_opcode    = IR[31:27];
  assign w_unused_ir = ^IR[26:0];

  instr_decoder u_instr_decoder (
    .i_opcode (w_opcode),
    .o_class  (w_class)
  );

  assign w_alu  = w_class[CLS_ALU];
  assign w_ld   = w_class[CLS_LD];
  assign w_st   = w_class[CLS_ST];
  assign w_br   = w_class[CLS_BR];
  assign w_halt = w_class[CLS_HALT];
`ifdef MULDIV_EN
  logic w_md;
  assign w_md  = w_class[CLS_MD];
  assign w_nop = w_class[CLS_NOP];
`else
  assign w_nop = w_class[CLS_NOP] | w_class[CLS_MD];
  assign HIin    = 1'b0;
  assign LOin    = 1'b0;
  assign Zhighin = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) r_state <= S_RST;
    else       r_state <= w_next_state;
  end

  // w_last marks the final step of an instruction, where Stop is honoured.
  always_comb begin
    w_next_state = r_state;
    w_last       = 1'b0;
    case (r_state)
      S_RST:  w_next_state = S_T0;
      S_T0:   w_next_state = S_T1;
      S_T1:   w_next_state = S_T2;
      S_T2:   w_next_state = S_T3;
      S_T3: begin
        if (w_halt)     w_next_state = S_HALT;
        else if (w_nop) w_last       = 1'b1;
        else            w_next_state = S_T4;
      end
      S_T4:   w_next_state = S_T5;
      S_T5: begin
        if (w_alu) w_last       = 1'b1;
        else       w_next_state = S_T6;
      end
      S_T6: begin
        if (w_ld || w_st) w_next_state = S_T7;
        else              w_last       = 1'b1;
      end
      S_T7:   w_last       = 1'b1;
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_RST;
    endcase
    if (w_last) w_next_state = Stop ? S_HALT : S_T0;
  end

  assign Run = (r_state != S_RST) && (r_state != S_HALT);

  always_comb begin
    ALU_op = ALU_ADD;
    {PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zlowin, Rin, CONin}   = '0;
    {IncPC, Read, Write, Gra, Grb, Grc}                   = '0;
`ifdef MULDIV_EN
    {HIin, LOin, Zhighin} = '0;
`endif
    case (r_state)
      S_T0: {PCout, MARin, IncPC, PCin} = '1;
      S_T1: {Read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        if (w_alu)             {Grb, Rout, Yin}   = '1;
        if (w_ld || w_st)      {Grb, BAout, Yin}  = '1;
        if (w_br)              {Gra, Rout, CONin} = '1;
`ifdef MULDIV_EN
        if (w_md)              {Gra, Rout, Yin}   = '1;
`endif
      end
      S_T4: begin
        if (w_alu) begin
          {Grc, Rout, Zlowin} = '1;
          ALU_op = alu_sel(w_opcode);
        end
        if (w_ld || w_st)      {Cout, Zlowin} = '1;
        if (w_br)              {PCout, Yin}   = '1;
`ifdef MULDIV_EN
        if (w_md) begin
          {Grb, Rout, Zlowin, Zhighin} = '1;
          ALU_op = alu_sel(w_opcode);
        end
`endif
      end
      S_T5: begin
        if (w_alu)             {Zlowout, Gra, Rin} = '1;
        if (w_ld || w_st)      {Zlowout, MARin}    = '1;
        if (w_br)              {Cout, Zlowin}      = '1;
`ifdef MULDIV_EN
        if (w_md)              {Zlowout, LOin}     = '1;
`endif
      end
      S_T6: begin
        if (w_ld)              {Read, MDRin}       = '1;
        if (w_st)              {Gra, Rout, MDRin}  = '1;
        if (w_br && CON_FF)    {Zlowout, PCin}     = '1;
`ifdef MULDIV_EN
        if (w_md)              {Zhighout, HIin}    = '1;
`endif
      end
      S_T7: begin
        if (w_ld)              {MDRout, Gra, Rin}  = '1;
        if (w_st)              Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected output vectors are queued
// when an instruction is issued and compared one clock at a time.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, CON_FF, Stop;
  logic [31:0] IR;
  logic        Run;
  logic [3:0]  ALU_op;
  logic        PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin, CONin;
  logic        IncPC, Read, Write, Gra, Grb, Grc;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Run(Run), .ALU_op(ALU_op),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc)
  );

  always #5 clock = ~clock;

  logic [28:0] w_obs;
  assign w_obs = {Run, ALU_op,
                  PCout, MDRout, Zlowout, Zhighout, Rout, BAout, Cout,
                  PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, HIin, LOin, Rin, CONin,
                  IncPC, Read, Write, Gra, Grb, Grc};

  localparam logic [28:0] ZERO     = 29'd0;
  localparam logic [28:0] M_RUN    = 29'd1 << 28;
  localparam logic [28:0] PCOUT    = 29'd1 << 23;
  localparam logic [28:0] MDROUT   = 29'd1 << 22;
  localparam logic [28:0] ZLOWOUT  = 29'd1 << 21;
  localparam logic [28:0] ZHIGHOUT = 29'd1 << 20;
  localparam logic [28:0] ROUT     = 29'd1 << 19;
  localparam logic [28:0] BAOUT    = 29'd1 << 18;
  localparam logic [28:0] COUT     = 29'd1 << 17;
  localparam logic [28:0] PCIN     = 29'd1 << 16;
  localparam logic [28:0] MARIN    = 29'd1 << 15;
  localparam logic [28:0] MDRIN    = 29'd1 << 14;
  localparam logic [28:0] IRIN     = 29'd1 << 13;
  localparam logic [28:0] YIN      = 29'd1 << 12;
  localparam logic [28:0] ZLOWIN   = 29'd1 << 11;
  localparam logic [28:0] ZHIGHIN  = 29'd1 << 10;
  localparam logic [28:0] HIIN     = 29'd1 << 9;
  localparam logic [28:0] LOIN     = 29'd1 << 8;
  localparam logic [28:0] RIN      = 29'd1 << 7;
  localparam logic [28:0] CONIN    = 29'd1 << 6;
  localparam logic [28:0] INCPC    = 29'd1 << 5;
  localparam logic [28:0] READ     = 29'd1 << 4;
  localparam logic [28:0] WRITE    = 29'd1 << 3;
  localparam logic [28:0] GRA      = 29'd1 << 2;
  localparam logic [28:0] GRB      = 29'd1 << 1;
  localparam logic [28:0] GRC      = 29'd1 << 0;

  function automatic logic [28:0] alu_f(input logic [3:0] code);
    alu_f = {1'b0, code, 24'd0};
  endfunction

  typedef struct {
    string       tag;
    logic [28:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string tag, input logic [28:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    exp_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<queued entry>", w_obs);
    end else begin
      e = q.pop_front();
      assert (w_obs === e.v) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, w_obs, e.v);
      end
    end
  endtask

  // Issues one instruction starting from T0; max_n > 0 truncates the checked steps.
  task automatic do_instr(input logic [31:0] ir, input logic con, input logic stp,
                          input int max_n, input string name);
    logic [28:0] e [8];
    logic [4:0]  op;
    int          n;
    op = ir[31:27];
    for (int i = 0; i < 8; i++) e[i] = ZERO;
    e[0] = M_RUN | PCOUT | MARIN | INCPC | PCIN;
    e[1] = M_RUN | READ | MDRIN;
    e[2] = M_RUN | MDROUT | IRIN;
    e[3] = M_RUN;
    n = 4;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        e[3] = M_RUN | GRB | ROUT | YIN;
        e[4] = M_RUN | GRC | ROUT | ZLOWIN | alu_f(4'(op - 5'd3));
        e[5] = M_RUN | ZLOWOUT | GRA | RIN;
        n = 6;
      end
      5'b00000, 5'b00010: begin
        e[3] = M_RUN | GRB | BAOUT | YIN;
        e[4] = M_RUN | COUT | ZLOWIN;
        e[5] = M_RUN | ZLOWOUT | MARIN;
        e[6] = (op == 5'b00000) ? (M_RUN | READ | MDRIN) : (M_RUN | GRA | ROUT | MDRIN);
        e[7] = (op == 5'b00000) ? (M_RUN | MDROUT | GRA | RIN) : (M_RUN | WRITE);
        n = 8;
      end
      5'b10010: begin
        e[3] = M_RUN | GRA | ROUT | CONIN;
        e[4] = M_RUN | PCOUT | YIN;
        e[5] = M_RUN | COUT | ZLOWIN;
        e[6] = con ? (M_RUN | ZLOWOUT | PCIN) : M_RUN;
        n = 7;
      end
`ifdef MULDIV_EN
      5'b01111, 5'b10000: begin
        e[3] = M_RUN | GRA | ROUT | YIN;
        e[4] = M_RUN | GRB | ROUT | ZLOWIN | ZHIGHIN |
               alu_f((op == 5'b01111) ? 4'b0100 : 4'b0101);
        e[5] = M_RUN | ZLOWOUT | LOIN;
        e[6] = M_RUN | ZHIGHOUT | HIIN;
        n = 7;
      end
`endif
      default: n = 4;
    endcase
    if (max_n > 0 && max_n < n) n = max_n;
    for (int i = 0; i < n; i++) push($sformatf("%s_T%0d", name, i), e[i]);
    tick();
    sample();
    IR     = ir;
    CON_FF = con;
    Stop   = stp;
    for (int i = 1; i < n; i++) begin
      tick();
      sample();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear  = 1'b1;
    IR     = 32'h0;
    CON_FF = 1'b0;
    Stop   = 1'b0;
    tick(); push("rst0", ZERO); sample();
    tick(); push("rst1", ZERO); sample();
    clear = 1'b0;

    do_instr(32'h18918000, 1'b0, 1'b0, 0, "add");
    do_instr(32'h20000000, 1'b0, 1'b0, 0, "sub");
    do_instr(32'h28000000, 1'b1, 1'b0, 0, "and");
    do_instr(32'h30000000, 1'b0, 1'b0, 0, "or");
    do_instr(32'h92800005, 1'b1, 1'b0, 0, "br_taken");
    do_instr(32'h92800005, 1'b0, 1'b0, 0, "br_not");
    do_instr(32'h00900010, 1'b0, 1'b0, 0, "ld");
    do_instr(32'h10000000, 1'b0, 1'b0, 0, "st");
    do_instr(32'hD0000000, 1'b0, 1'b0, 0, "nop");
    do_instr(32'h08000000, 1'b0, 1'b0, 0, "undef");
    do_instr(32'h78000000, 1'b0, 1'b0, 0, "mul");
    do_instr(32'h80000000, 1'b0, 1'b0, 0, "div");

    do_instr(32'h18918000, 1'b0, 1'b1, 0, "add_stop");
    tick(); push("stop_halt0", ZERO); sample();
    Stop = 1'b0;
    tick(); push("stop_halt1", ZERO); sample();
    clear = 1'b1;
    tick(); push("stop_clear", ZERO); sample();
    clear = 1'b0;

    do_instr(32'hD8000000, 1'b0, 1'b0, 0, "halt");
    for (int i = 0; i < 20; i++) begin
      tick(); push($sformatf("halt_hold%0d", i), ZERO); sample();
    end
    clear = 1'b1;
    tick(); push("halt_clear", ZERO); sample();
    clear = 1'b0;

    do_instr(32'h10000000, 1'b0, 1'b0, 5, "st_abort");
    clear = 1'b1;
    tick(); push("st_abort_rst", ZERO); sample();
    clear = 1'b0;

    do_instr(32'hD0000000, 1'b0, 1'b1, 0, "nop_stop_clr");
    clear = 1'b1;
    tick(); push("clr_over_stop", ZERO); sample();
    clear = 1'b0;
    Stop  = 1'b0;

    do_instr(32'h00900010, 1'b0, 1'b0, 0, "ld_after");
    do_instr(32'hD0000000, 1'b0, 1'b0, 1, "final_t0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
